// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx -- framed UART 8N1 packet transmitter.
// Sends PREFIX, addr, len, payload[0..len-1], crc (XOR of payload) as
// 8N1 bytes on tx, each followed by GAP_BITS idle-high bit times.
// Ports:
//   clk_100, n_rst          clock (rising edge), async active-low reset
//   start                   frame request, sampled only while idle
//   pkt_addr, pkt_len       header fields, latched when start is accepted
//   data_in/valid/ready     payload byte handshake (ready only in PAY_WAIT)
//   tx                      UART line, idle high
//   busy, done              frame in progress / one-cycle end-of-frame pulse
module uart_pkt_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] PREFIX       = 8'hDD,
  parameter int         GAP_BITS     = 0
) (
  input  logic       clk_100,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] pkt_addr,
  input  logic [7:0] pkt_len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFIX, S_ADDR, S_LEN, S_PAY_WAIT, S_PAY, S_CRC
  } state_e;
  typedef enum logic [1:0] {B_START, B_DATA, B_STOP, B_GAP} bph_e;

  state_e        state_q, state_d;
  bph_e          bph_q, bph_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    addr_q, addr_d, len_q, len_d, cnt_q, cnt_d;
  logic [7:0]    crc_q, crc_d, byte_q, byte_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;
  logic          sending, bit_end, byte_end;

  assign sending = state_q inside {S_PREFIX, S_ADDR, S_LEN, S_PAY, S_CRC};
  assign bit_end = sending && (baud_q == BAUD_LAST);

  // State register
  always_ff @(posedge clk_100 or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;  bph_q  <= B_START; baud_q <= '0;
      bidx_q  <= '0;      gap_q  <= '0;      addr_q <= '0;
      len_q   <= '0;      cnt_q  <= '0;      crc_q  <= '0;
      byte_q  <= '0;      tx_q   <= 1'b1;    busy_q <= 1'b0;
      done_q  <= 1'b0;    rdy_q  <= 1'b0;
    end else begin
      state_q <= state_d; bph_q  <= bph_d;   baud_q <= baud_d;
      bidx_q  <= bidx_d;  gap_q  <= gap_d;   addr_q <= addr_d;
      len_q   <= len_d;   cnt_q  <= cnt_d;   crc_q  <= crc_d;
      byte_q  <= byte_d;  tx_q   <= tx_d;    busy_q <= busy_d;
      done_q  <= done_d;  rdy_q  <= rdy_d;
    end
  end

  // Next state: bit sequencer plus frame FSM
  always_comb begin
    state_d = state_q; bph_d = bph_q; baud_d = baud_q; bidx_d = bidx_q;
    gap_d = gap_q; addr_d = addr_q; len_d = len_q; cnt_d = cnt_q;
    crc_d = crc_q; byte_d = byte_q; byte_end = 1'b0;

    if (sending) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
      if (bit_end) begin
        unique case (bph_q)
          B_START: begin bph_d = B_DATA; bidx_d = '0; end
          B_DATA:  if (bidx_q == 3'd7) bph_d = B_STOP;
                   else bidx_d = bidx_q + 3'd1;
          B_STOP:  if (GAP_BITS > 0) begin bph_d = B_GAP; gap_d = '0; end
                   else byte_end = 1'b1;
          B_GAP:   if (gap_q == GAP_LAST) byte_end = 1'b1;
                   else gap_d = gap_q + GW'(1);
        endcase
      end
    end

    // Every transition into a sending state loads byte_d and restarts at
    // the start bit; baud is already zero whenever a byte has just ended.
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PREFIX; addr_d = pkt_addr; len_d = pkt_len;
        cnt_d = '0; crc_d = '0; byte_d = PREFIX; bph_d = B_START; baud_d = '0;
      end
      S_PREFIX: if (byte_end) begin
        state_d = S_ADDR; byte_d = addr_q; bph_d = B_START;
      end
      S_ADDR: if (byte_end) begin
        state_d = S_LEN; byte_d = len_q; bph_d = B_START;
      end
      S_LEN: if (byte_end) begin
        if (len_q == 8'd0) begin
          state_d = S_CRC; byte_d = crc_q; bph_d = B_START;
        end else state_d = S_PAY_WAIT;
      end
      S_PAY_WAIT: if (data_valid && rdy_q) begin
        state_d = S_PAY; byte_d = data_in; crc_d = crc_q ^ data_in;
        cnt_d = cnt_q + 8'd1; bph_d = B_START; baud_d = '0;
      end
      S_PAY: if (byte_end) begin
        if (cnt_q == len_q) begin
          state_d = S_CRC; byte_d = crc_q; bph_d = B_START;
        end else state_d = S_PAY_WAIT;
      end
      S_CRC: if (byte_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they come straight off flops
  always_comb begin
    tx_d = 1'b1;
    if (state_d inside {S_PREFIX, S_ADDR, S_LEN, S_PAY, S_CRC}) begin
      unique case (bph_d)
        B_START: tx_d = 1'b0;
        B_DATA:  tx_d = byte_d[bidx_d];
        default: tx_d = 1'b1;
      endcase
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
    rdy_d  = (state_d == S_PAY_WAIT);
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign data_ready = rdy_q;
endmodule
